// File: rtl/dcache_pkg.sv
// Shared geometry and FSM state type for the data-cache fill controller.
package dcache_pkg;

  localparam int unsigned INDEX_W        = 6;
  localparam int unsigned OFFSET_W       = 6;
  localparam int unsigned LINES          = 64;
  localparam int unsigned BEATS          = 8;
  localparam int unsigned BYTES_PER_BEAT = 8;
  localparam int unsigned TAG_LSB        = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MREQ,
    FILL,
    REREAD
  } state_e;

endpackage

// File: rtl/dcache_tag_array.sv
// Tag/valid store: 64 entries, one shared index for read, invalidate and fill,
// combinational read and a single-cycle clear of every valid bit.
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int unsigned TAG_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr_all,
  input  logic               i_inv,
  input  logic               i_wr,
  input  logic [INDEX_W-1:0] i_index,
  input  logic [TAG_W-1:0]   i_wr_tag,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_clr_all) begin
      r_valid <= '0;
    end else if (i_inv) begin
      r_valid[i_index] <= 1'b0;
    end else if (i_wr) begin
      r_valid[i_index] <= 1'b1;
    end
  end

  // Tags need no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (i_wr) begin
      r_tag[i_index] <= i_wr_tag;
    end
  end

  assign o_rd_valid = r_valid[i_index];
  assign o_rd_tag   = r_tag[i_index];

endmodule

// File: rtl/dcache_fill_ctrl.sv
// Read-only data-cache controller: tag lookup, line fill one byte per cycle into the data RAM.
// Optional hit/miss counters are enabled with DCACHE_STATS_EN.
module dcache_fill_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_data,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [63:0]       mem_rdata,
  output logic              cram_wen,
  output logic [5:0]        cram_index,
  output logic [5:0]        cram_offset,
  output logic [7:0]        cram_wdata,
  input  logic [63:0]       cram_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int unsigned TAG_W = ADDR_W - TAG_LSB;

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_beat, r_byte;
  logic [63:0]       r_buf;
  logic              r_buf_full;

  logic              w_valid, w_hit, w_clr_all, w_inv, w_tag_wr;
  logic [TAG_W-1:0]  w_tag;
  logic              w_unused_addr;

  assign w_unused_addr = ^{req_addr[2:0], r_addr[2:0]};

  dcache_tag_array #(
    .TAG_W (TAG_W)
  ) u_tag_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_all  (w_clr_all),
    .i_inv      (w_inv),
    .i_wr       (w_tag_wr),
    .i_index    (r_addr[11:6]),
    .i_wr_tag   (r_addr[ADDR_W-1:TAG_LSB]),
    .o_rd_valid (w_valid),
    .o_rd_tag   (w_tag)
  );

  assign w_hit        = w_valid && (w_tag == r_addr[ADDR_W-1:TAG_LSB]);
  assign resp_data    = cram_rdata;
  assign mem_req_addr = {r_addr[ADDR_W-1:6], 6'b000000};

  always_comb begin
    w_state_d     = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    mem_rready    = 1'b0;
    cram_wen      = 1'b0;
    cram_index    = r_addr[11:6];
    cram_offset   = {r_addr[5:3], 3'b000};
    cram_wdata    = 8'h00;
    w_clr_all     = 1'b0;
    w_inv         = 1'b0;
    w_tag_wr      = 1'b0;
    unique case (r_state)
      IDLE: begin
        cram_index  = req_addr[11:6];
        cram_offset = {req_addr[5:3], 3'b000};
        if (flush) begin
          w_clr_all = 1'b1;
        end else begin
          req_ready = 1'b1;
          if (req_valid) w_state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (w_hit) begin
          resp_valid = 1'b1;
          if (resp_ready) w_state_d = IDLE;
        end else begin
          w_inv     = 1'b1;
          w_state_d = MREQ;
        end
      end
      MREQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_d = FILL;
      end
      FILL: begin
        mem_rready = !r_buf_full;
        if (r_buf_full) begin
          cram_wen    = 1'b1;
          cram_offset = {r_beat, r_byte};
          cram_wdata  = r_buf[{r_byte, 3'b000} +: 8];
          if (r_beat == 3'(BEATS - 1) && r_byte == 3'(BYTES_PER_BEAT - 1)) begin
            w_tag_wr  = 1'b1;
            w_state_d = REREAD;
          end
        end
      end
      REREAD: w_state_d = LOOKUP;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_beat     <= 3'd0;
      r_byte     <= 3'd0;
      r_buf      <= 64'd0;
      r_buf_full <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == IDLE && !flush && req_valid) begin
        r_addr <= {req_addr[ADDR_W-1:3], 3'b000};
      end
      if (r_state == MREQ) begin
        r_beat     <= 3'd0;
        r_byte     <= 3'd0;
        r_buf_full <= 1'b0;
      end else if (r_state == FILL) begin
        if (!r_buf_full) begin
          if (mem_rvalid) begin
            r_buf      <= mem_rdata;
            r_buf_full <= 1'b1;
          end
        end else begin
          r_byte <= r_byte + 3'd1;
          // Last byte of the beat drains the buffer so the next beat can be accepted.
          if (r_byte == 3'(BYTES_PER_BEAT - 1)) begin
            r_beat     <= r_beat + 3'd1;
            r_buf_full <= 1'b0;
          end
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_refill;
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // r_refill marks the LOOKUP that follows a fill so its hit is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refill   <= 1'b0;
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (r_state == REREAD) r_refill <= 1'b1;
      else if (r_state == IDLE) r_refill <= 1'b0;
      if (r_state == LOOKUP && w_hit && resp_ready && !r_refill &&
          r_hit_cnt != 32'hFFFF_FFFF) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (r_state == LOOKUP && !w_hit && r_miss_cnt != 32'hFFFF_FFFF) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_fill_ctrl.sv
// Directed bench for dcache_fill_ctrl with a byte-wide RAM model and a beat-based memory model.
module tb_dcache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, resp_valid, resp_ready, flush;
  logic [31:0] req_addr, mem_req_addr;
  logic [63:0] resp_data, mem_rdata, cram_rdata;
  logic        mem_req_valid, mem_req_ready, mem_rvalid, mem_rready, cram_wen;
  logic [5:0]  cram_index, cram_offset;
  logic [7:0]  cram_wdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_fill_ctrl #(
    .ADDR_W (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rready    (mem_rready),
    .mem_rdata     (mem_rdata),
    .cram_wen      (cram_wen),
    .cram_index    (cram_index),
    .cram_offset   (cram_offset),
    .cram_wdata    (cram_wdata),
    .cram_rdata    (cram_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
`endif
  );

  // Memory image: line 0x1040-style addresses get the counting pattern, bit 13 set inverts it.
  function automatic logic [63:0] beat_data(input logic [31:0] line, input int b);
    logic [63:0] p;
    p = 64'h0706050403020100 + 64'(b) * 64'h0808080808080808;
    return line[13] ? ~p : p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Data RAM model: registered read of 8 bytes, byte write.
  logic [7:0] ram [4096];
  always @(posedge clk) begin
    if (cram_wen) ram[int'({cram_index, cram_offset})] <= cram_wdata;
    else for (int k = 0; k < 8; k++) cram_rdata[8*k +: 8] <= ram[int'({cram_index, cram_offset}) + k];
  end

  // Memory responder.
  int          n_memreq = 0;
  int          beats_sent = 0;
  int          mem_gap = 0;
  logic [31:0] last_mem_addr = 32'd0;
  initial begin
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 64'd0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && mem_req_valid) begin
        last_mem_addr = mem_req_addr;
        n_memreq++;
        beats_sent = 0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int b = 0; b < 8 && rst_n; b++) begin
          for (int g = 0; g < mem_gap && rst_n; g++) begin
            @(posedge clk); #1;
          end
          mem_rvalid = 1'b1;
          mem_rdata  = beat_data(last_mem_addr, b);
          for (int t = 0; t < 100 && rst_n && !mem_rready; t++) begin
            @(posedge clk); #1;
          end
          if (rst_n && mem_rready) begin
            @(posedge clk); #1;
            beats_sent++;
          end
          mem_rvalid = 1'b0;
        end
      end
    end
  end

  // Write monitor: every RAM write must follow the fill order of exp_line.
  logic [31:0] exp_line = 32'd0;
  int          wr_cnt = 0;
  int          wr_bad = 0;
  int          wr_pos = 0;
  always @(negedge clk) begin
    logic [63:0] w;
    logic [7:0]  eb;
    if (!rst_n) begin
      wr_pos = 0;
    end else if (cram_wen) begin
      w  = beat_data(exp_line, wr_pos / 8);
      eb = w[8*(wr_pos % 8) +: 8];
      if (cram_index != exp_line[11:6] || cram_offset != 6'(wr_pos) || cram_wdata != eb) wr_bad++;
      wr_cnt++;
      wr_pos = (wr_pos + 1) % 64;
    end
  end

  int stall_bad = 0;

  task automatic load(input logic [31:0] addr, input int stall,
                      output logic [63:0] data, output int lat);
    int n;
    req_addr  = addr;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && rst_n && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    data = resp_data;
    if (resp_valid) begin
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        if (resp_data !== data || !resp_valid) stall_bad++;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input int stall,
                         input logic [63:0] exp_d, input bit miss);
    int m, w, b, sb, lat;
    logic [63:0] d;
    exp_line = {addr[31:6], 6'b000000};
    m = n_memreq; w = wr_cnt; b = wr_bad; sb = stall_bad;
    load(addr, stall, d, lat);
    check({tag, "_data"}, d, exp_d);
    check({tag, "_memreq"}, 64'(n_memreq - m), miss ? 64'd1 : 64'd0);
    check({tag, "_writes"}, 64'(wr_cnt - w), miss ? 64'd64 : 64'd0);
    check({tag, "_wrorder"}, 64'(wr_bad - b), 64'd0);
    if (miss) check({tag, "_memaddr"}, 64'(last_mem_addr), 64'(exp_line));
    else      check({tag, "_lat"}, 64'(lat), 64'd1);
    if (stall > 0) check({tag, "_stable"}, 64'(stall_bad - sb), 64'd0);
  endtask

  initial begin
    int          m_snap, lat;
    logic [63:0] d;
    req_valid = 1'b0; req_addr = 32'd0; resp_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_rready", 64'(mem_rready), 64'd0);
    check("rst_cram_wen", 64'(cram_wen), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_load("cold", 32'h0000_1040, 0, 64'h0706050403020100, 1'b1);
    do_load("hit", 32'h0000_1078, 0, 64'h3F3E3D3C3B3A3938, 1'b0);
    do_load("conflict", 32'h0000_2040, 0, 64'hF8F9FAFBFCFDFEFF, 1'b1);
    mem_gap = 3;
    do_load("backpressure", 32'h0000_1040, 5, 64'h0706050403020100, 1'b1);
    mem_gap = 0;

    flush = 1'b1;
    #1;
    check("flush_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    do_load("post_flush", 32'h0000_1078, 0, 64'h3F3E3D3C3B3A3938, 1'b1);

    m_snap = n_memreq;
    fork
      do_load("fill_flush", 32'h0000_2048, 0, 64'hF0F1F2F3F4F5F6F7, 1'b1);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (n_memreq > m_snap && beats_sent >= 2) break;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    do_load("fill_flush_hit", 32'h0000_2048, 0, 64'hF0F1F2F3F4F5F6F7, 1'b0);
`ifdef DCACHE_STATS_EN
    check("stats_hit", 64'(hit_cnt), 64'd2);
    check("stats_miss", 64'(miss_cnt), 64'd5);
`endif

    exp_line = 32'h0000_1040;
    m_snap = n_memreq;
    fork
      load(32'h0000_1040, 0, d, lat);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (n_memreq > m_snap && beats_sent >= 4) break;
        end
        check("abort_reached_beat4", 64'(beats_sent), 64'd4);
        rst_n = 1'b0;
        #1;
        check("abort_mem_rready", 64'(mem_rready), 64'd0);
        check("abort_cram_wen", 64'(cram_wen), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    @(posedge clk); #1;
    do_load("after_rst", 32'h0000_1040, 0, 64'h0706050403020100, 1'b1);
    do_load("after_rst_hit", 32'h0000_1078, 0, 64'h3F3E3D3C3B3A3938, 1'b0);
`ifdef DCACHE_STATS_EN
    check("stats_rst_hit", 64'(hit_cnt), 64'd1);
    check("stats_rst_miss", 64'(miss_cnt), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
